// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the RV32M multiply control stage.
//   state_t   - control FSM states (IDLE, REQ, WAIT, RESP)
//   F3_*      - funct3 encodings of the four multiply ops
//   sign_of() - operand signedness {rs1_signed, rs2_signed} for a funct3
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;

  // MUL only keeps the low word, which does not depend on signedness, so it
  // shares MULH's encoding.
  function automatic logic [1:0] sign_of(input logic [2:0] funct3);
    logic [1:0] s;
    case (funct3)
      F3_MUL:    s = 2'b11;
      F3_MULH:   s = 2'b11;
      F3_MULHSU: s = 2'b10;
      default:   s = 2'b00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mdu_result_sel.sv
// mdu_result_sel: picks the architectural result word out of a 64-bit product.
//   funct3 in  3        multiply op (MUL selects the low word)
//   prod   in  2*XLEN   full product
//   word   out XLEN     selected result word
// Illegal funct3 values never reach this block; they are handled by the FSM.
module mdu_result_sel
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3,
  input  logic [2*XLEN-1:0] prod,
  output logic [XLEN-1:0]   word
);

  assign word = (funct3 == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

endmodule

// File: rtl/mdu_mul_ctrl.sv
// mdu_mul_ctrl: control stage around a handshaked 33x33 multiplier.
// Accepts one RV32M multiply op at a time, drives the multiplier, captures the
// product, selects the low/high word and presents a tagged writeback result.
//
// Ports:
//   clock, reset (async, active-high), flush
//   issue side:     in_valid/in_ready, in_funct3, in_rs1, in_rs2, in_rd
//   multiplier req: mul_in_valid/mul_in_ready, mul_in_sign, mul_in_a, mul_in_b
//   multiplier rsp: mul_out_valid/mul_out_ready, mul_out_prod
//   mul_flush:      combinational copy of flush
//   writeback:      out_valid/out_ready, out_rd, out_data
//
// Optional build macro: MDU_MUL_REUSE_EN adds a one-entry product cache so an
// op with the same operands as the last multiplied pair (and compatible sign)
// completes without visiting the multiplier.
module mdu_mul_ctrl
  import mdu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  output logic              in_ready,
  input  logic              in_valid,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [RD_W-1:0]   in_rd,
  output logic              mul_flush,
  input  logic              mul_in_ready,
  output logic              mul_in_valid,
  output logic [1:0]        mul_in_sign,
  output logic [XLEN-1:0]   mul_in_a,
  output logic [XLEN-1:0]   mul_in_b,
  output logic              mul_out_ready,
  input  logic              mul_out_valid,
  input  logic [2*XLEN-1:0] mul_out_prod,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [RD_W-1:0]   out_rd,
  output logic [XLEN-1:0]   out_data
);

  state_t            state;
  logic [2:0]        op_f3;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [RD_W-1:0]   op_rd;
  logic [XLEN-1:0]   res_data;

  logic [XLEN-1:0]   cap_word;
  logic              hit;
  logic [XLEN-1:0]   hit_word;

  // All handshake outputs decode straight from the state register, so they
  // are glitch-free and fall to their reset values as soon as reset rises.
  assign in_ready      = (state == IDLE) && !flush;
  assign mul_flush     = flush;
  assign mul_in_valid  = (state == REQ);
  assign mul_in_sign   = sign_of(op_f3);
  assign mul_in_a      = op_a;
  assign mul_in_b      = op_b;
  assign mul_out_ready = (state == WAIT);
  assign out_valid     = (state == RESP);
  assign out_rd        = op_rd;
  assign out_data      = res_data;

  mdu_result_sel #(.XLEN(XLEN)) u_cap_sel (
    .funct3 (op_f3),
    .prod   (mul_out_prod),
    .word   (cap_word)
  );

`ifdef MDU_MUL_REUSE_EN
  logic [2*XLEN-1:0] c_prod;
  logic [XLEN-1:0]   c_a;
  logic [XLEN-1:0]   c_b;
  logic [1:0]        c_sign;
  logic              c_valid;

  // Refilled on every real product capture; flush leaves it intact because
  // the cached product is still mathematically correct for its operands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_prod  <= '0;
      c_a     <= '0;
      c_b     <= '0;
      c_sign  <= 2'b00;
    end else if ((state == WAIT) && mul_out_valid && !flush) begin
      c_valid <= 1'b1;
      c_prod  <= mul_out_prod;
      c_a     <= op_a;
      c_b     <= op_b;
      c_sign  <= sign_of(op_f3);
    end
  end

  // MUL's low word is sign-independent, so it may reuse any cached sign.
  assign hit = c_valid && (in_rs1 == c_a) && (in_rs2 == c_b) &&
               ((in_funct3 == F3_MUL) || (sign_of(in_funct3) == c_sign));

  mdu_result_sel #(.XLEN(XLEN)) u_hit_sel (
    .funct3 (in_funct3),
    .prod   (c_prod),
    .word   (hit_word)
  );
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_f3    <= 3'b000;
      op_a     <= '0;
      op_b     <= '0;
      op_rd    <= '0;
      res_data <= '0;
    end else if (flush) begin
      // Flush wins over any handshake in the same cycle; nothing is captured.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_f3 <= in_funct3;
            op_a  <= in_rs1;
            op_b  <= in_rs2;
            op_rd <= in_rd;
            if (in_funct3[2]) begin
              res_data <= '0;
              state    <= RESP;
            end else if (hit) begin
              res_data <= hit_word;
              state    <= RESP;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (mul_in_ready) state <= WAIT;
        end
        WAIT: begin
          if (mul_out_valid) begin
            res_data <= cap_word;
            state    <= RESP;
          end
        end
        RESP: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_mul_ctrl.sv
module tb_mdu_mul_ctrl;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_ready;
  logic        in_valid;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        mul_flush;
  logic        mul_in_ready;
  logic        mul_in_valid;
  logic [1:0]  mul_in_sign;
  logic [31:0] mul_in_a;
  logic [31:0] mul_in_b;
  logic        mul_out_ready;
  logic        mul_out_valid;
  logic [63:0] mul_out_prod;
  logic        out_ready;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  mdu_mul_ctrl #(.XLEN(32), .RD_W(5)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .in_ready      (in_ready),
    .in_valid      (in_valid),
    .in_funct3     (in_funct3),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rd         (in_rd),
    .mul_flush     (mul_flush),
    .mul_in_ready  (mul_in_ready),
    .mul_in_valid  (mul_in_valid),
    .mul_in_sign   (mul_in_sign),
    .mul_in_a      (mul_in_a),
    .mul_in_b      (mul_in_b),
    .mul_out_ready (mul_out_ready),
    .mul_out_valid (mul_out_valid),
    .mul_out_prod  (mul_out_prod),
    .out_ready     (out_ready),
    .out_valid     (out_valid),
    .out_rd        (out_rd),
    .out_data      (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MDU_MUL_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  // Full 64-bit product of the operands, each extended per its sign bit.
  function automatic logic [63:0] full_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] s);
    logic [63:0] x, y;
    x = s[1] ? {{32{a[31]}}, a} : {32'h0, a};
    y = s[0] ? {{32{b[31]}}, b} : {32'h0, b};
    return x * y;
  endfunction

  function automatic logic [1:0] ref_sign(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001: return 2'b11;
      3'b010:         return 2'b10;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    if (f3[2]) return 32'h0;
    p = full_mul(a, b, ref_sign(f3));
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural multiplier: one-deep, product valid the cycle after request.
  logic        pend;
  logic [63:0] sprod;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend  <= 1'b0;
      sprod <= 64'h0;
    end else if (flush) begin
      pend <= 1'b0;
    end else begin
      if (mul_out_valid && mul_out_ready) pend <= 1'b0;
      if (mul_in_valid && mul_in_ready) begin
        pend  <= 1'b1;
        sprod <= full_mul(mul_in_a, mul_in_b, mul_in_sign);
      end
    end
  end
  assign mul_out_valid = pend;
  assign mul_out_prod  = sprod;

  // Reference model state for the optional product cache.
  bit          cv;
  logic [31:0] ca, cb;
  logic [1:0]  cs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one op and follows it to writeback. stall>0 holds out_ready low
  // for that many RESP cycles and checks the result stays frozen.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input bit chk_lat, input bit rnd,
                        input int stall, output int lat);
    int guard;
    bit saw_req;
    logic [1:0] seen_sign;
    logic [1:0] s;
    bit hit, exp_mul;
    s       = ref_sign(f3);
    hit     = REUSE && cv && (a == ca) && (b == cb) && !f3[2] && (f3 == 3'b000 || s == cs);
    exp_mul = !f3[2] && !hit;
    seen_sign = 2'b00;
    @(negedge clock);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    out_ready = (stall == 0);
    #1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      #1;
      guard++;
    end
    if (guard >= 50) check({tag, " accept timeout"}, 0, 1);
    @(negedge clock);
    in_valid = 1'b0;
    lat      = 1;
    saw_req  = 1'b0;
    guard    = 0;
    while (guard < 200) begin
      if (rnd) mul_in_ready = 1'($urandom_range(0, 1));
      #1;
      if (mul_in_valid) begin
        saw_req   = 1'b1;
        seen_sign = mul_in_sign;
      end
      if (out_valid) break;
      @(negedge clock);
      lat++;
      guard++;
    end
    mul_in_ready = 1'b1;
    check({tag, " out_valid timeout"}, (guard >= 200), 0);
    if (chk_lat) check({tag, " latency"}, lat, hit || f3[2] ? 1 : 3);
    check({tag, " mul issued"}, saw_req, exp_mul);
    if (exp_mul) check({tag, " mul_in_sign"}, seen_sign, s);
    check({tag, " out_data"}, out_data, exp_data);
    check({tag, " out_rd"}, out_rd, rd);
    if (stall > 0) begin
      for (int i = 1; i < stall; i++) begin
        @(negedge clock);
        #1;
        check({tag, " stall out_valid"}, out_valid, 1);
        check({tag, " stall out_data"}, out_data, exp_data);
        check({tag, " stall out_rd"}, out_rd, rd);
        check({tag, " stall in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      #1;
      check({tag, " post-handshake out_valid"}, out_valid, 0);
      check({tag, " post-handshake in_ready"}, in_ready, 1);
    end
    if (exp_mul) begin
      cv = 1'b1;
      ca = a;
      cb = b;
      cs = s;
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat;
    logic [31:0] pool[6];
    vecs[0] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'hFFFF_FFFE};
    vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3,  32'hFFFF_FFFF};
    vecs[2] = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4,  32'hFFFF_FFFF};
    vecs[3] = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd5,  32'hFFFF_FFFE};
    vecs[4] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000};
    vecs[5] = '{3'b011, 32'h8000_0000, 32'h0000_0002, 5'd1,  32'h0000_0001};
    vecs[6] = '{3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9,  32'h0000_0000};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_funct3 = 3'b000;
    in_rs1 = 32'h0; in_rs2 = 32'h0; in_rd = 5'd0;
    mul_in_ready = 1'b1; out_ready = 1'b1;
    cv = 1'b0; ca = 32'h0; cb = 32'h0; cs = 2'b00;
    #1;
    check("reset in_ready", in_ready, 1);
    check("reset mul_in_valid", mul_in_valid, 0);
    check("reset mul_out_ready", mul_out_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_rd", out_rd, 0);
    check("reset out_data", out_data, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
             vecs[i].exp_data, 1'b1, 1'b0, 0, lat);

    // Writeback stalled for 5 cycles in RESP.
    run_op("stall", 3'b001, 32'h0001_0000, 32'h0001_0000, 5'd12, 32'h0000_0001,
           1'b1, 1'b0, 5, lat);

    // Flush while the product is being offered in WAIT.
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'b000; in_rs1 = 32'h1234; in_rs2 = 32'h77; in_rd = 5'd9;
    @(negedge clock);
    in_valid = 1'b0;
    @(negedge clock);
    #1;
    check("flush WAIT handshake offered", {mul_out_ready, mul_out_valid}, 2'b11);
    flush = 1'b1;
    #1;
    check("flush mul_flush", mul_flush, 1);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check("flush in_ready next", in_ready, 1);
    check("flush out_valid", out_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check("flush out_valid stays low", out_valid, 0);
    end
    flush = 1'b1;
    #1;
    check("flush blocks in_ready", in_ready, 0);
    flush = 1'b0;

    // Asynchronous reset in the middle of a REQ cycle.
    @(negedge clock);
    in_valid = 1'b1; in_funct3 = 3'b011; in_rs1 = 32'h5; in_rs2 = 32'h6; in_rd = 5'd3;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("pre-reset mul_in_valid", mul_in_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async reset mul_in_valid", mul_in_valid, 0);
    check("async reset in_ready", in_ready, 1);
    check("async reset out_rd", out_rd, 0);
    check("async reset out_data", out_data, 0);
    @(negedge clock);
    reset = 1'b0;
    cv = 1'b0;
    run_op("illegal after reset", 3'b100, 32'hDEAD_BEEF, 32'h3, 5'd22, 32'h0,
           1'b1, 1'b0, 0, lat);

`ifdef MDU_MUL_REUSE_EN
    run_op("reuse MULH", 3'b001, 32'd7, 32'd9, 5'd6, 32'd0, 1'b1, 1'b0, 0, lat);
    run_op("reuse MUL", 3'b000, 32'd7, 32'd9, 5'd7, 32'd63, 1'b1, 1'b0, 0, lat);
    check("reuse MUL one-cycle", lat, 1);
    run_op("reuse MULHU miss", 3'b011, 32'd7, 32'd9, 5'd8, 32'd0, 1'b1, 1'b0, 0, lat);
    check("reuse MULHU full latency", lat, 3);
`endif

    // Randomized ops with a stalling multiplier against the reference model.
    pool[0] = 32'd7;        pool[1] = 32'd9;        pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h2;       pool[5] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      f3 = ($urandom_range(0, 3) == 0) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      run_op($sformatf("rand%0d", i), f3, a, b, 5'($urandom_range(0, 31)),
             ref_result(f3, a, b), 1'b0, 1'b1, 0, lat);
    end

    repeat (2) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_mul_ctrl.md
Name: mdu_mul_ctrl

Overview:
- Control stage wrapped around the handshaked 33x33 product unit (MUL_test).
- Accepts one RV32M multiply op at a time from issue (funct3, rs1/rs2 values, rd).
- Drives the multiplier with operands and sign bits, consumes the 64-bit product, selects the low or high word and presents a tagged writeback result.
- Sits directly upstream of, and downstream of, the multiplier.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- RD_W, 5, destination register tag width.

Ports:
- clock  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous active-high reset.
- flush  in  1  pipeline flush; drops the in-flight op.
- in_ready  out  1  op accepted when in_valid & in_ready.
- in_valid  in  1  op request.
- in_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is illegal.
- in_rs1, in_rs2  in  XLEN  operands.
- in_rd  in  RD_W  destination tag.
- mul_flush  out  1  equals flush, combinational.
- mul_in_ready  in  1  multiplier ready.
- mul_in_valid  out  1  multiplier request.
- mul_in_sign  out  2  [1] = rs1 signed, [0] = rs2 signed.
- mul_in_a, mul_in_b  out  XLEN  latched operands.
- mul_out_ready  out  1  product ready.
- mul_out_valid  in  1  product valid.
- mul_out_prod  in  2*XLEN  product.
- out_ready  in  1  writeback ready.
- out_valid  out  1  result valid.
- out_rd  out  RD_W  result tag.
- out_data  out  XLEN  result word.

Behaviour:
- Reset (async, any state): state = IDLE; op/result registers = 0.
  - Resulting outputs: in_ready=1 (unless flush), mul_in_valid=0, mul_out_ready=0, out_valid=0, out_rd=0, out_data=0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - in_ready = !flush.
  - On accept, latch funct3, rs1, rs2, rd. Go to REQ, or to RESP if funct3[2]=1 (out_data=0).
- REQ:
  - mul_in_valid=1; mul_in_a/b = latched operands.
  - mul_in_sign: MUL=11, MULH=11, MULHSU=10, MULHU=00.
  - On mul_in_ready go to WAIT.
- WAIT:
  - mul_out_ready=1.
  - On mul_out_valid, capture out_data: prod[31:0] for MUL, prod[63:32] otherwise. Go to RESP.
- RESP:
  - out_valid=1; out_rd and out_data are registered and stable while stalled.
  - On out_ready go to IDLE. No new accept in the same cycle; no back-to-back overlap.
- Flush:
  - Any state goes to IDLE next cycle; nothing is captured and out_valid is never raised for the dropped op.
  - mul_flush lets the multiplier drop or refuse the same op.
  - flush has priority over every simultaneous handshake in that cycle.
- Latency, with the multiplier always ready:
  - Accept at cycle 0, REQ at 1, product at 2, out_valid at cycle 3.
  - Throughput is 1 op per 4 cycles with out_ready=1.
- Operand and tag registers change only on accept.

Optional Feature:
- Macro: MDU_MUL_REUSE_EN.
- When defined: add a product cache of prod[63:0], a, b, sign and valid.
  - Written on every WAIT capture; cleared only by reset; flush does not clear it.
  - In IDLE, an accepted op hits when valid=1 and rs1==a and rs2==b, and either:
    - funct3 is MUL (any cached sign), or
    - the required sign equals the cached sign.
  - On a hit, skip REQ/WAIT, select the word from the cache and go to RESP: out_valid 1 cycle after accept.
  - This makes a MULH;MUL pair take 4+1 cycles.
- When undefined: no cache registers; every op goes through the multiplier.

Decomposition:
- Package mdu_pkg:
  - state_t enum (IDLE/REQ/WAIT/RESP).
  - funct3 constants F3_MUL/F3_MULH/F3_MULHSU/F3_MULHU.
  - function sign_of(funct3) returning the 2-bit sign.
- Sub-module mdu_result_sel: combinational funct3 + 64-bit product to 32-bit word. Shared by the capture path and the cache path.

Test Plan:
- MULHU rs1=0xFFFFFFFF rs2=0xFFFFFFFF, multiplier ready -> mul_in_sign=00; out_valid at cycle 3; out_data=0xFFFFFFFE; out_rd echoed.
- MULH 0xFFFFFFFF x 0x00000002 -> sign=11; out_data=0xFFFFFFFF. MULHSU with the same operands -> sign=10; out_data=0xFFFFFFFF. MUL with the same operands -> out_data=0xFFFFFFFE.
- out_ready held low 5 cycles in RESP -> out_valid, out_rd and out_data stable; in_ready=0 throughout; IDLE the cycle after the handshake.
- flush asserted in WAIT with mul_out_valid=1 -> no capture; out_valid never rises; in_ready=1 the next cycle; mul_flush=1 in that cycle.
- reset asserted mid-REQ, between clock edges -> outputs return immediately to reset values; in_funct3=100 op -> out_valid at cycle 1, out_data=0, no mul_in_valid.
- MDU_MUL_REUSE_EN: MULH 7 x 9 followed by MUL 7 x 9 -> second op produces no mul_in_valid, out_valid 1 cycle after accept, out_data=63. A following MULHU 7 x 9 misses and issues sign=00.
